// File: rtl/cpu_selftest_sequencer_pkg.sv
// Shared types and helpers for the CPU self-test sequencer.
package cpu_selftest_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_RUN  = 3'd2,
    ST_READ = 3'd3,
    ST_CMP  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Width of a test index; a single test still needs a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_selftest_sequencer_if.sv
// Sequencer <-> cpu/rom/ram cluster: reset, program select, halt and debug read port.
interface cpu_selftest_sequencer_if #(
  parameter int SEL_W   = 1,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic               cpu_reset_n;
  logic [SEL_W-1:0]   prog_sel;
  logic [RADDR_W-1:0] dbg_rd_addr;
  logic [DATA_W-1:0]  dbg_rd_data;
  logic               cpu_halt;

  modport master (
    output cpu_reset_n, prog_sel, dbg_rd_addr,
    input  dbg_rd_data, cpu_halt
  );

  modport slave (
    input  cpu_reset_n, prog_sel, dbg_rd_addr,
    output dbg_rd_data, cpu_halt
  );
endinterface

// File: rtl/cpu_selftest_sequencer_timer.sv
// Saturating phase counter shared by the reset-hold and run-timeout phases.
module cpu_selftest_sequencer_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Count enabled cycles from zero, stopping at the limit; clr wins so each phase starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (en && cnt != limit)   cnt <= cnt + W'(1);
  end

  // Terminal count: this enabled cycle is the limit-th one of the phase
  assign tc = en && ((cnt + W'(1)) == limit);

endmodule

// File: rtl/cpu_selftest_sequencer.sv
// Runs NUM_TESTS ROM programs back-to-back and records a pass/timeout vector.
//
//   state   | meaning
//   IDLE    | waiting for start, CPU held in reset
//   RST     | prog_sel driven, CPU held in reset for RST_CYCLES
//   RUN     | CPU released, waiting for halt or timeout
//   READ    | debug address presented, CPU left running/halted
//   CMP     | debug data compared, advance to next test or finish
//   DONE    | as IDLE, with done raised
module cpu_selftest_sequencer
  import cpu_selftest_sequencer_pkg::*;
#(
  parameter int NUM_TESTS      = 2,
  parameter int DATA_W         = 32,
  parameter int RADDR_W        = 5,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int RST_CYCLES     = 4,
  localparam int SEL_W = sel_width(NUM_TESTS),
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [NUM_TESTS*DATA_W-1:0]   exp_values,
  input  logic [NUM_TESTS*RADDR_W-1:0]  chk_regs,
  cpu_selftest_sequencer_if.master      cpu,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_TESTS-1:0]          pass_mask,
  output logic [NUM_TESTS-1:0]          timeout_mask,
  output logic [CNT_W-1:0]              last_cycles
);

  // One timer serves both phases, so it is sized for the longer of the two limits.
  localparam int TW = $clog2(((RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES) + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_TESTS - 1);

  state_t             state, nxt;
  logic [SEL_W-1:0]   idx;
  logic [TW-1:0]      tmr_cnt, tmr_limit;
  logic               tmr_tc, tmr_en, tmr_clr;
  logic               run_exit;
  logic [DATA_W-1:0]  exp_arr [NUM_TESTS];
  logic [RADDR_W-1:0] chk_arr [NUM_TESTS];

  for (genvar i = 0; i < NUM_TESTS; i++) begin : g_unpack
    assign exp_arr[i] = exp_values[i*DATA_W +: DATA_W];
    assign chk_arr[i] = chk_regs[i*RADDR_W +: RADDR_W];
  end

  assign tmr_limit = (state == ST_RST) ? TW'(RST_CYCLES) : TW'(TIMEOUT_CYCLES);
  assign tmr_en    = (state == ST_RST) || (state == ST_RUN);
  assign tmr_clr   = (nxt != state);
  assign run_exit  = cpu.cpu_halt || tmr_tc;

  cpu_selftest_sequencer_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .cnt   (tmr_cnt),
    .tc    (tmr_tc)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  // Next-state logic; start is only looked at while idle or done, so a sweep cannot be aborted
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) nxt = ST_RST;
      ST_RST:           if (tmr_tc) nxt = ST_RUN;
      ST_RUN:           if (run_exit) nxt = ST_READ;
      ST_READ:          nxt = ST_CMP;
      ST_CMP:           nxt = (idx == LAST_IDX) ? ST_DONE : ST_RST;
      default:          nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; CPU stays out of reset through READ/CMP so its registers survive
  always_comb begin
    cpu.cpu_reset_n = 1'b0;
    cpu.dbg_rd_addr = '0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      ST_RST:  busy = 1'b1;
      ST_RUN:  begin busy = 1'b1; cpu.cpu_reset_n = 1'b1; end
      ST_READ: begin busy = 1'b1; cpu.cpu_reset_n = 1'b1; cpu.dbg_rd_addr = chk_arr[idx]; end
      ST_CMP:  begin busy = 1'b1; cpu.cpu_reset_n = 1'b1; end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign cpu.prog_sel = idx;

  // Per-test bookkeeping: index, run length, timeout and pass flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      pass_mask    <= '0;
      timeout_mask <= '0;
      last_cycles  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx          <= '0;
            pass_mask    <= '0;
            timeout_mask <= '0;
          end
        end
        ST_RUN: begin
          if (run_exit) begin
            last_cycles <= CNT_W'(tmr_cnt + TW'(1));
            // halt in the same cycle as the limit counts as a clean halt
            if (!cpu.cpu_halt) timeout_mask[idx] <= 1'b1;
          end
        end
        ST_CMP: begin
          pass_mask[idx] <= (cpu.dbg_rd_data == exp_arr[idx]) && !timeout_mask[idx];
          if (idx != LAST_IDX) idx <= idx + SEL_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_selftest_sequencer.sv
// Self-checking bench: two sequencer instances (2 tests / 1 test) against behavioural CPUs.
module tb_cpu_selftest_sequencer;
  localparam int RST  = 4;
  localparam int TMO0 = 500;
  localparam int TMO1 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start0, start1;
  logic       busy0, done0, busy1, done1;
  logic [1:0] pass0, tmo0;
  logic [0:0] pass1, tmo1;
  logic [8:0] last0;
  logic [4:0] last1;

  int          halt_after [2][2];
  logic [4:0]  chk [2][2];
  logic [31:0] expv [2][2];
  logic [31:0] rf [2][2][32];
  int          cyc0, cyc1;
  int          n_cmp = 0;
  int          n_err = 0;

  cpu_selftest_sequencer_if #(.SEL_W(1), .DATA_W(32), .RADDR_W(5)) cpu0 ();
  cpu_selftest_sequencer_if #(.SEL_W(1), .DATA_W(32), .RADDR_W(5)) cpu1 ();

  cpu_selftest_sequencer dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .exp_values({expv[0][1], expv[0][0]}), .chk_regs({chk[0][1], chk[0][0]}),
    .cpu(cpu0), .busy(busy0), .done(done0),
    .pass_mask(pass0), .timeout_mask(tmo0), .last_cycles(last0)
  );

  cpu_selftest_sequencer #(.NUM_TESTS(1), .TIMEOUT_CYCLES(TMO1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .exp_values(expv[1][0]), .chk_regs(chk[1][0]),
    .cpu(cpu1), .busy(busy1), .done(done1),
    .pass_mask(pass1), .timeout_mask(tmo1), .last_cycles(last1)
  );

  // Behavioural CPUs: cycle count since reset release, programmed halt point, registered debug read
  always @(posedge clk) begin
    cyc0 <= cpu0.cpu_reset_n ? cyc0 + 1 : 0;
    cyc1 <= cpu1.cpu_reset_n ? cyc1 + 1 : 0;
    cpu0.dbg_rd_data <= rf[0][cpu0.prog_sel][cpu0.dbg_rd_addr];
    cpu1.dbg_rd_data <= rf[1][cpu1.prog_sel][cpu1.dbg_rd_addr];
  end

  assign cpu0.cpu_halt = cpu0.cpu_reset_n && (halt_after[0][cpu0.prog_sel] != 0)
                         && (cyc0 >= halt_after[0][cpu0.prog_sel] - 1);
  assign cpu1.cpu_halt = cpu1.cpu_reset_n && (halt_after[1][cpu1.prog_sel] != 0)
                         && (cyc1 >= halt_after[1][cpu1.prog_sel] - 1);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic randomize_cfg(input int d);
    int nt, tmo;
    nt  = (d == 0) ? 2 : 1;
    tmo = (d == 0) ? TMO0 : TMO1;
    for (int i = 0; i < nt; i++) begin
      for (int a = 0; a < 32; a++) rf[d][i][a] = (a == 0) ? 32'd0 : $urandom;
      chk[d][i] = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 4))
        0:       halt_after[d][i] = 0;
        1:       halt_after[d][i] = tmo;
        2:       halt_after[d][i] = tmo + 1;
        default: halt_after[d][i] = int'($urandom_range(1, 60));
      endcase
      expv[d][i] = rf[d][i][chk[d][i]];
      if ($urandom_range(0, 1) == 1) expv[d][i] = expv[d][i] ^ (32'd1 << $urandom_range(0, 31));
    end
  endtask

  // Predicts results from the sweep rules, runs one sweep, compares everything observable
  task automatic run_and_check(input int d, input int repulse_at, input string tag);
    int nt, tmo, run, lat, lat_exp, last_exp;
    logic [1:0]  pm, tm;
    logic [31:0] val;
    nt = (d == 0) ? 2 : 1;
    tmo = (d == 0) ? TMO0 : TMO1;
    lat_exp = 1; last_exp = 0; pm = 2'b00; tm = 2'b00;
    for (int i = 0; i < nt; i++) begin
      if (halt_after[d][i] != 0 && halt_after[d][i] <= tmo) run = halt_after[d][i];
      else begin run = tmo; tm[i] = 1'b1; end
      val = (chk[d][i] == 5'd0) ? 32'd0 : rf[d][i][chk[d][i]];
      pm[i] = !tm[i] && (val == expv[d][i]);
      lat_exp += RST + run + 2;
      last_exp = run;
    end

    @(negedge clk);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    lat = 1;
    while (!((d == 0) ? done0 : done1) && lat < 5000) begin
      if (lat == 2) check($sformatf("%s busy_mid", tag), 64'((d == 0) ? busy0 : busy1), 64'd1);
      start0 = (d == 0 && lat == repulse_at);
      @(negedge clk);
      lat++;
    end
    start0 = 1'b0;
    check($sformatf("%s latency", tag), 64'(lat), 64'(lat_exp));
    repeat (3) @(negedge clk);
    check($sformatf("%s done", tag), 64'((d == 0) ? done0 : done1), 64'd1);
    check($sformatf("%s busy_end", tag), 64'((d == 0) ? busy0 : busy1), 64'd0);
    check($sformatf("%s cpu_reset_n", tag),
          64'((d == 0) ? cpu0.cpu_reset_n : cpu1.cpu_reset_n), 64'd0);
    check($sformatf("%s pass_mask", tag), (d == 0) ? 64'(pass0) : 64'(pass1),
          (d == 0) ? 64'(pm) : 64'(pm[0]));
    check($sformatf("%s timeout_mask", tag), (d == 0) ? 64'(tmo0) : 64'(tmo1),
          (d == 0) ? 64'(tm) : 64'(tm[0]));
    check($sformatf("%s last_cycles", tag), (d == 0) ? 64'(last0) : 64'(last1), 64'(last_exp));
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s busy", tag), 64'(busy0), 64'd0);
    check($sformatf("%s done", tag), 64'(done0), 64'd0);
    check($sformatf("%s pass_mask", tag), 64'(pass0), 64'd0);
    check($sformatf("%s timeout_mask", tag), 64'(tmo0), 64'd0);
    check($sformatf("%s last_cycles", tag), 64'(last0), 64'd0);
    check($sformatf("%s cpu_reset_n", tag), 64'(cpu0.cpu_reset_n), 64'd0);
    check($sformatf("%s prog_sel", tag), 64'(cpu0.prog_sel), 64'd0);
    check($sformatf("%s dbg_rd_addr", tag), 64'(cpu0.dbg_rd_addr), 64'd0);
  endtask

  task automatic load_sum_fib(input int h0, input int h1, input logic [31:0] exp1);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 32; a++) rf[d][i][a] = (a == 0) ? 32'd0 : $urandom;
    rf[0][0][29] = 32'd55;
    rf[0][1][3]  = 32'd55;
    chk[0][0] = 5'd29; chk[0][1] = 5'd3;
    expv[0][0] = 32'd55; expv[0][1] = exp1;
    halt_after[0][0] = h0; halt_after[0][1] = h1;
  endtask

  initial begin
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2; i++) begin
        halt_after[d][i] = 0; chk[d][i] = '0; expv[d][i] = '0;
        for (int a = 0; a < 32; a++) rf[d][i][a] = '0;
      end
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("idle");

    load_sum_fib(30, 25, 32'd55);
    run_and_check(0, -1, "both_pass");

    load_sum_fib(30, 25, 32'd56);
    run_and_check(0, -1, "exp1_wrong");

    load_sum_fib(0, 0, 32'd55);
    run_and_check(0, -1, "no_halt");

    load_sum_fib(TMO0, TMO0 + 1, 32'd55);
    run_and_check(0, -1, "halt_at_limit");

    load_sum_fib(30, 25, 32'd55);
    run_and_check(0, 10, "restart_ignored");

    // reset pulse while test 1 is running
    load_sum_fib(30, 25, 32'd55);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (RST + 30 + 2 + RST + 3) @(negedge clk);
    check("pre_rst busy", 64'(busy0), 64'd1);
    check("pre_rst cpu_reset_n", 64'(cpu0.cpu_reset_n), 64'd1);
    check("pre_rst prog_sel", 64'(cpu0.prog_sel), 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("post_rst");
    run_and_check(0, -1, "after_rst");

    // single-test instance
    for (int a = 0; a < 32; a++) rf[1][0][a] = (a == 0) ? 32'd0 : $urandom;
    chk[1][0] = 5'd0; expv[1][0] = 32'd0; halt_after[1][0] = 10;
    run_and_check(1, -1, "single_x0");
    expv[1][0] = 32'd1;
    run_and_check(1, -1, "single_x0_bad");
    expv[1][0] = 32'd0; halt_after[1][0] = TMO1;
    run_and_check(1, -1, "single_at_limit");
    halt_after[1][0] = TMO1 + 1;
    run_and_check(1, -1, "single_timeout");

    for (int r = 0; r < 6; r++) begin
      randomize_cfg(0);
      run_and_check(0, -1, $sformatf("rand0_%0d", r));
      randomize_cfg(1);
      run_and_check(1, -1, $sformatf("rand1_%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
